// File: rtl/multicycle_seq.sv
// Multi-cycle sequencer for the simplified RISC-V core.
// Walks each instruction through fetch, decode, execute and writeback,
// owning the PC, the instruction register, the retire counter and a
// sticky trap raised on unsupported opcodes.
//
// Handshake: imem_req is raised in FETCH and held until a cycle in which
// imem_gnt is high; that cycle accepts the request. imem_rdata is taken
// on the first cycle imem_rvalid is high, either together with the grant
// or later in WAIT_RD. imem_rvalid is ignored in every other state.
//
// All outputs except imem_addr (which is the PC register itself) are
// registered and updated together with the state register.
module multicycle_seq #(
  parameter int WIDTH    = 8,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             ex_en,
  output logic             rf_wen,
  output logic [WIDTH-1:0] pc,
  output logic             busy,
  output logic             trap,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT_RD = 3'd2,
    DECODE  = 3'd3,
    EXEC    = 3'd4,
    WB      = 3'd5,
    TRAP    = 3'd6
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [WIDTH-1:0] PC_INIT = RESET_PC[WIDTH-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state;

  // The fetch address is the PC; it only moves in WB, so it is stable
  // for as long as imem_req is high.
  assign imem_addr = pc;

  // Sequencer state, datapath strobes and architectural counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= PC_INIT;
      instr      <= '0;
      retire_cnt <= '0;
      trap       <= 1'b0;
      imem_req   <= 1'b0;
      ex_en      <= 1'b0;
      rf_wen     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a branch below re-asserts them.
      imem_req <= 1'b0;
      ex_en    <= 1'b0;
      rf_wen   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_gnt) begin
            if (imem_rvalid) begin
              instr <= imem_rdata;
              state <= DECODE;
            end else begin
              state <= WAIT_RD;
            end
          end else begin
            imem_req <= 1'b1;
          end
        end
        WAIT_RD: begin
          if (imem_rvalid) begin
            instr <= imem_rdata;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (instr[6:0] == OPC_OP || instr[6:0] == OPC_OP_IMM) begin
            state <= EXEC;
            ex_en <= 1'b1;
          end else begin
            // Faulting PC and retire count stay frozen for inspection.
            state <= TRAP;
            trap  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        EXEC: begin
          state  <= WB;
          rf_wen <= 1'b1;
        end
        WB: begin
          pc <= pc + WIDTH'(4);
          if (retire_cnt != CNT_MAX) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
          end
          if (halt_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        TRAP: begin
          // Only reset leaves this state.
          state <= TRAP;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_seq.sv
// Bench for multicycle_seq: one default-parameter instance driven by a
// configurable instruction-memory responder, plus a small-width instance
// for PC wrap and retire-counter saturation.
module tb_multicycle_seq;

  localparam logic [31:0] ADD = 32'h003100B3;
  localparam logic [31:0] BRANCH = 32'h00000063;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        ex_en;
  logic        rf_wen;
  logic [7:0]  pc;
  logic        busy;
  logic        trap;
  logic [15:0] retire_cnt;

  logic        rst1 = 1'b1;
  logic        start1 = 1'b0;
  logic        halt1 = 1'b0;
  logic        req1;
  logic [3:0]  addr1;
  logic        gnt1 = 1'b0;
  logic        rv1 = 1'b0;
  logic [31:0] rdata1 = '0;
  logic [31:0] instr1;
  logic        ex1;
  logic        wen1;
  logic [3:0]  pc1;
  logic        busy1;
  logic        trap1;
  logic [1:0]  cnt1;

  multicycle_seq dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
    .ex_en(ex_en), .rf_wen(rf_wen), .pc(pc), .busy(busy), .trap(trap),
    .retire_cnt(retire_cnt)
  );

  multicycle_seq #(.WIDTH(4), .RESET_PC(12), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst1), .start(start1), .halt_req(halt1),
    .imem_req(req1), .imem_addr(addr1), .imem_gnt(gnt1),
    .imem_rvalid(rv1), .imem_rdata(rdata1), .instr(instr1),
    .ex_en(ex1), .rf_wen(wen1), .pc(pc1), .busy(busy1), .trap(trap1),
    .retire_cnt(cnt1)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- memory responders ----------------
  logic [31:0] mem [64];
  logic        mem_en = 1'b1;
  int          gnt_delay = 0;
  int          rv_delay = 0;

  initial begin
    int req_cnt;
    int pend;
    logic [5:0] lat_addr;
    req_cnt = 0;
    pend = 0;
    lat_addr = '0;
    for (int i = 0; i < 64; i++) mem[i] = ADD;
    forever begin
      @(negedge clk);
      if (mem_en) begin
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        if (rst) begin
          pend = 0;
          req_cnt = 0;
        end else if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata = mem[lat_addr];
          end
        end else if (imem_req) begin
          if (req_cnt == gnt_delay) begin
            imem_gnt = 1'b1;
            req_cnt = 0;
            if (rv_delay == 0) begin
              imem_rvalid = 1'b1;
              imem_rdata = mem[imem_addr[7:2]];
            end else begin
              pend = rv_delay;
              lat_addr = imem_addr[7:2];
            end
          end else begin
            req_cnt++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      gnt1 = req1;
      rv1 = req1;
      rdata1 = ADD;
    end
  end

  // ---------------- scoreboard ----------------
  // Each entry is {pc, instr} expected on a retire (rf_wen pulse).
  logic [39:0] exp_q[$];

  initial begin
    logic [39:0] exp_v;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ex_en === 1'b1 || rf_wen === 1'b1) begin
          checks++;
          if (ex_en === 1'b1 && rf_wen === 1'b1) begin
            errors++;
            $display("FAIL strobe_overlap ex_en=%b rf_wen=%b required not both", ex_en, rf_wen);
          end
        end
        if (rf_wen === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL retire_unexpected pc=%h instr=%h required no retire", pc, instr);
          end else begin
            exp_v = exp_q.pop_front();
            if ({pc, instr} !== exp_v) begin
              errors++;
              $display("FAIL retire_data got %h required %h", {pc, instr}, exp_v);
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    halt_req = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    rst1 = 1'b1;
    step();
    step();
    checks++;
    if ({imem_req, ex_en, rf_wen, busy, trap} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b required 00000", {imem_req, ex_en, rf_wen, busy, trap});
    end
    checks++;
    if (pc !== 8'd0 || instr !== 32'd0 || retire_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_regs pc=%h instr=%h cnt=%h required 0 0 0", pc, instr, retire_cnt);
    end
    checks++;
    if (pc1 !== 4'd12 || cnt1 !== 2'd0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_small pc=%h cnt=%h busy=%b required c 0 0", pc1, cnt1, busy1);
    end
    rst = 1'b0;
    rst1 = 1'b0;
  endtask

  task automatic test_zero_wait();
    do_reset();
    exp_q.push_back({8'd0, ADD});
    exp_q.push_back({8'd4, ADD});
    exp_q.push_back({8'd8, ADD});
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      checks++;
      if (rf_wen !== (n % 4 == 0)) begin
        errors++;
        $display("FAIL zw_rf_wen cycle %0d got %b required %b", n, rf_wen, (n % 4 == 0));
      end
      if (n == 12) halt_req = 1'b1;
      step();
    end
    halt_req = 1'b0;
    checks++;
    if (pc !== 8'd12 || retire_cnt !== 16'd3 || busy !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL zw_final pc=%0d cnt=%0d busy=%b req=%b required 12 3 0 0", pc, retire_cnt, busy, imem_req);
    end
  endtask

  task automatic test_delayed();
    int req_n;
    int addr_bad;
    gnt_delay = 3;
    rv_delay = 2;
    do_reset();
    exp_q.push_back({8'd0, ADD});
    start = 1'b1;
    step();
    start = 1'b0;
    req_n = 0;
    addr_bad = 0;
    for (int n = 1; n <= 12; n++) begin
      if (imem_req === 1'b1) begin
        req_n++;
        if (imem_addr !== 8'd0) addr_bad++;
      end
      checks++;
      if (rf_wen !== (n == 9)) begin
        errors++;
        $display("FAIL dly_rf_wen cycle %0d got %b required %b", n, rf_wen, (n == 9));
      end
      if (n == 9) halt_req = 1'b1;
      step();
    end
    halt_req = 1'b0;
    checks++;
    if (req_n != 4 || addr_bad != 0) begin
      errors++;
      $display("FAIL dly_req req_cycles=%0d addr_changes=%0d required 4 0", req_n, addr_bad);
    end
    checks++;
    if (pc !== 8'd4 || retire_cnt !== 16'd1) begin
      errors++;
      $display("FAIL dly_final pc=%0d cnt=%0d required 4 1", pc, retire_cnt);
    end
    gnt_delay = 0;
    rv_delay = 0;
  endtask

  task automatic test_trap();
    mem[2] = BRANCH;
    do_reset();
    exp_q.push_back({8'd0, ADD});
    exp_q.push_back({8'd4, ADD});
    start = 1'b1;
    step();
    for (int n = 1; n <= 12; n++) step();
    checks++;
    if (trap !== 1'b1 || pc !== 8'd8 || retire_cnt !== 16'd2 || busy !== 1'b0 || instr !== BRANCH) begin
      errors++;
      $display("FAIL trap_entry trap=%b pc=%0d cnt=%0d busy=%b instr=%h required 1 8 2 0 %h",
               trap, pc, retire_cnt, busy, instr, BRANCH);
    end
    for (int n = 0; n < 8; n++) begin
      start = ~start;
      step();
      checks++;
      if (trap !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0 || pc !== 8'd8) begin
        errors++;
        $display("FAIL trap_sticky trap=%b req=%b busy=%b pc=%0d required 1 0 0 8", trap, imem_req, busy, pc);
      end
    end
    start = 1'b0;
    do_reset();
    checks++;
    if (trap !== 1'b0 || pc !== 8'd0) begin
      errors++;
      $display("FAIL trap_clear trap=%b pc=%0d required 0 0", trap, pc);
    end
    mem[2] = ADD;
  endtask

  task automatic test_halt_resume();
    do_reset();
    exp_q.push_back({8'd0, ADD});
    exp_q.push_back({8'd4, ADD});
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      if (n == 8) halt_req = 1'b1;
      step();
    end
    halt_req = 1'b0;
    checks++;
    if (busy !== 1'b0 || pc !== 8'd8 || retire_cnt !== 16'd2) begin
      errors++;
      $display("FAIL halt_idle busy=%b pc=%0d cnt=%0d required 0 8 2", busy, pc, retire_cnt);
    end
    for (int n = 0; n < 3; n++) step();
    checks++;
    if (busy !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL halt_stays busy=%b req=%b required 0 0", busy, imem_req);
    end
    exp_q.push_back({8'd8, ADD});
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'd8) begin
      errors++;
      $display("FAIL resume_fetch req=%b addr=%0d required 1 8", imem_req, imem_addr);
    end
    for (int n = 1; n <= 4; n++) begin
      if (n == 4) halt_req = 1'b1;
      step();
    end
    halt_req = 1'b0;
    checks++;
    if (pc !== 8'd12 || retire_cnt !== 16'd3) begin
      errors++;
      $display("FAIL resume_final pc=%0d cnt=%0d required 12 3", pc, retire_cnt);
    end
  endtask

  task automatic test_wrap_saturate();
    int pulses;
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 20; n++) begin
      if (wen1 === 1'b1) pulses++;
      if (n == 5) begin
        checks++;
        if (pc1 !== 4'd0 || cnt1 !== 2'd1) begin
          errors++;
          $display("FAIL wrap_pc pc=%0d cnt=%0d required 0 1", pc1, cnt1);
        end
      end
      if (n == 17) begin
        checks++;
        if (pc1 !== 4'd12 || cnt1 !== 2'd3) begin
          errors++;
          $display("FAIL sat_hold pc=%0d cnt=%0d required 12 3", pc1, cnt1);
        end
      end
      if (n == 20) halt1 = 1'b1;
      step();
    end
    halt1 = 1'b0;
    checks++;
    if (pulses != 5 || cnt1 !== 2'd3 || pc1 !== 4'd0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL sat_final pulses=%0d cnt=%0d pc=%0d busy=%b required 5 3 0 0", pulses, cnt1, pc1, busy1);
    end
  endtask

  task automatic test_reset_wait_rd();
    mem_en = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL rwr_fetch req=%b required 1", imem_req);
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rwr_wait req=%b busy=%b required 0 1", imem_req, busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    step();
    imem_rvalid = 1'b0;
    checks++;
    if (instr !== 32'd0 || pc !== 8'd0 || busy !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rwr_late_rvalid instr=%h pc=%0d busy=%b req=%b required 0 0 0 0", instr, pc, busy, imem_req);
    end
    step();
    checks++;
    if (busy !== 1'b0 || instr !== 32'd0) begin
      errors++;
      $display("FAIL rwr_idle busy=%b instr=%h required 0 0", busy, instr);
    end
    mem_en = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_zero_wait();
    test_delayed();
    test_trap();
    test_halt_resume();
    test_wrap_saturate();
    test_reset_wait_rd();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_seq.md
Name: multicycle_seq

Overview:
- Multi-cycle sequencer for the simplified RISC-V core.
- Fetches each instruction over a request/grant/rvalid instruction-memory handshake and holds it in an instruction register (IR).
- Steps the datapath through decode, execute and writeback, and gates the register-file write enable so it is asserted for exactly one cycle per retired instruction.
- Maintains the PC, a retire counter and a sticky trap on unsupported opcodes.

Parameters:
- WIDTH, 8, width of PC and instruction-memory address (byte address).
- RESET_PC, 0, PC value after reset.
- CNT_W, 16, width of retire counter.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  level; leaves IDLE when high
- halt_req  input  1  level; sampled in WB, stops after the current instruction retires
- imem_req  output  1  fetch request; held until granted
- imem_addr  output  WIDTH  fetch address (= PC); stable while imem_req high
- imem_gnt  input  1  request accepted
- imem_rvalid  input  1  imem_rdata valid
- imem_rdata  input  32  fetched instruction
- instr  output  32  IR contents, feeding decode/ctrl logic
- ex_en  output  1  high in EXEC; datapath operand/ALU result registers load
- rf_wen  output  1  register-file write strobe (decoder wen gated); high only in WB
- pc  output  WIDTH  current PC
- busy  output  1  high in any state except IDLE and TRAP
- trap  output  1  sticky illegal-opcode flag
- retire_cnt  output  CNT_W  instructions retired, saturating

Behaviour:
- Reset (rst=1 at edge) values:
  - state=IDLE, pc=RESET_PC, instr=0, retire_cnt=0, trap=0.
  - imem_req=0, ex_en=0, rf_wen=0, busy=0.
  - Reset mid-operation aborts any outstanding fetch; an imem_rvalid arriving after reset is ignored.
- States: IDLE, FETCH, WAIT_RD, DECODE, EXEC, WB, TRAP.
- IDLE: outputs low. start=1 -> FETCH next cycle.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_gnt=0: stay in FETCH.
  - imem_gnt=1 and imem_rvalid=1 in the same cycle: IR<=imem_rdata, -> DECODE.
  - imem_gnt=1 only: -> WAIT_RD.
- WAIT_RD:
  - imem_req=0; stay until imem_rvalid=1.
  - On imem_rvalid=1: IR<=imem_rdata, -> DECODE.
  - imem_rvalid is ignored in every state other than FETCH and WAIT_RD.
- DECODE: one cycle; checks opcode=IR[6:0].
  - Opcode OP (7'h33) or OP_IMM (7'h13) -> EXEC.
  - Any other opcode -> TRAP; pc and retire_cnt unchanged.
- EXEC: one cycle, ex_en=1 -> WB.
- WB: one cycle, rf_wen=1.
  - pc <= pc+4 modulo 2^WIDTH; wrap from 2^WIDTH-4 to 0 is silent.
  - retire_cnt increments, holding at 2^CNT_W-1.
  - Next state: halt_req=1 -> IDLE, else FETCH.
  - halt_req is ignored in every other state.
- TRAP:
  - trap=1, all strobes low, pc holds the faulting address.
  - Leaves only on rst; start is ignored.
- Latency with zero-wait memory (gnt and rvalid in the request cycle): 4 cycles per instruction (FETCH, DECODE, EXEC, WB).
  - Each grant-wait cycle adds 1.
  - Each cycle spent in WAIT_RD adds 1.
- Invariants:
  - rf_wen and ex_en are never high in the same cycle.
  - rf_wen is high for exactly one cycle per retire.
  - imem_req is never high outside FETCH.
  - instr only changes on a captured rvalid.

Test Plan:
- Reset, start=1, zero-wait memory returning ADD (0x003100B3) at pc 0,4,8 -> rf_wen pulses at cycles 4, 8, 12 after start; pc=12, retire_cnt=3.
- gnt delayed 3 cycles, then rvalid 2 cycles after gnt -> imem_req high for 4 cycles with imem_addr stable; instruction retires at cycle 4+3+2=9; no extra rf_wen pulse.
- IR=0x00000063 (branch opcode) at pc=8 -> TRAP entered after DECODE; trap=1, pc=8, retire_cnt unchanged, no rf_wen pulse; start toggling has no effect until rst.
- halt_req=1 held during WB of the 2nd instruction -> IDLE, busy=0, pc=8; start=1 later resumes fetch at addr 8.
- WIDTH=4, RESET_PC=12 -> after one retire pc=0 (wrap); CNT_W=2 with 5 retires -> retire_cnt=3 (saturated).
- rst asserted while in WAIT_RD, late rvalid arriving the cycle after reset -> state IDLE, instr=0, pc=RESET_PC, rvalid ignored.
